add_nbit_serial: RTL and testbench

Parametrised digit-serial adder/subtractor that adds two DATA_W-bit operands DIGIT_W bits per clock, rippling the carry through a register between digits. Operands enter and results leave over valid/ready handshakes, so the block sits behind any producer in the calc datapath and trades latency for area against the combinational adders. With DATA_W = DIGIT_W = 1 and i_cry = i_sub = 0 it reduces to a registered 1-bit half adder.

---
 rtl/add_nbit_serial.sv | 139 +++++++++++++
 tb/tb_add_nbit_serial.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_nbit_serial.sv
// add_nbit_serial
//   Digit-serial adder/subtractor. Adds two DATA_W-bit operands DIGIT_W bits
//   per clock, carrying between digits through a register. Operands are
//   taken over a valid/ready handshake and the result is offered the same way.
//
// Parameters
//   DATA_W  : operand/result width (must be a multiple of DIGIT_W)
//   DIGIT_W : bits processed per clock
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_vld    : operands valid          o_rdy : block can accept operands
//   i_num_a  : operand A               i_num_b : operand B
//   i_cry    : carry-in (borrow-in when subtracting)
//   i_sub    : 0 -> A + B + cry, 1 -> A - B - cry
//   o_vld    : result valid            i_rdy : downstream takes result
//   o_res    : result modulo 2^DATA_W
//   o_cry    : raw carry out of the MSB (subtract: 1 = no borrow)
//   o_ovf    : two's-complement signed overflow
module add_nbit_serial #(
   parameter int DATA_W  = 32,
   parameter int DIGIT_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_vld,
   output logic              o_rdy,
   input  logic [DATA_W-1:0] i_num_a,
   input  logic [DATA_W-1:0] i_num_b,
   input  logic              i_cry,
   input  logic              i_sub,
   output logic              o_vld,
   input  logic              i_rdy,
   output logic [DATA_W-1:0] o_res,
   output logic              o_cry,
   output logic              o_ovf
);

   localparam int N     = DATA_W / DIGIT_W;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                cry_reg;
   logic [DATA_W-1:0]   a_sh;
   logic [DATA_W-1:0]   b_sh;
   logic [DATA_W-1:0]   sum_sh;
   logic                a_msb;
   logic                b_msb;

   logic                accept;
   logic                last;
   logic [DIGIT_W:0]    dsum;
   logic [DATA_W-1:0]   sum_next;
   logic                ovf_next;

   assign accept = (state == IDLE) && i_vld;
   assign last   = (cnt == CNT_LAST);

   // Operands shift right one digit per cycle so the active digit is always
   // at the bottom; result digits enter the sum register from the top, so
   // after N cycles the sum register holds the full result in place.
   always_comb begin
      dsum     = {1'b0, a_sh[DIGIT_W-1:0]} + {1'b0, b_sh[DIGIT_W-1:0]}
               + {{DIGIT_W{1'b0}}, cry_reg};
      sum_next = (sum_sh >> DIGIT_W)
               | (DATA_W'(dsum[DIGIT_W-1:0]) << (DATA_W - DIGIT_W));
      ovf_next = (a_msb == b_msb) && (sum_next[DATA_W-1] != a_msb);
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         cry_reg <= 1'b0;
         o_rdy   <= 1'b1;
         o_vld   <= 1'b0;
         o_res   <= '0;
         o_cry   <= 1'b0;
         o_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_vld) begin
                  state   <= CALC;
                  cnt     <= '0;
                  // Subtraction is A + ~B + 1; a borrow-in removes the +1.
                  cry_reg <= i_cry ^ i_sub;
                  o_rdy   <= 1'b0;
               end
            end
            CALC: begin
               cry_reg <= dsum[DIGIT_W];
               cnt     <= cnt + CNT_W'(1);
               if (last) begin
                  state <= DONE;
                  cnt   <= '0;
                  o_vld <= 1'b1;
                  o_res <= sum_next;
                  o_cry <= dsum[DIGIT_W];
                  o_ovf <= ovf_next;
               end
            end
            DONE: begin
               if (i_rdy) begin
                  state <= IDLE;
                  o_vld <= 1'b0;
                  o_rdy <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               o_vld <= 1'b0;
               o_rdy <= 1'b1;
            end
         endcase
      end
   end

   // Operand and partial-sum datapath; contents are don't-care until loaded.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         a_sh  <= i_num_a;
         b_sh  <= i_num_b ^ {DATA_W{i_sub}};
         a_msb <= i_num_a[DATA_W-1];
         b_msb <= i_num_b[DATA_W-1] ^ i_sub;
      end else if (state == CALC) begin
         a_sh   <= a_sh >> DIGIT_W;
         b_sh   <= b_sh >> DIGIT_W;
         sum_sh <= sum_next;
      end
   end

endmodule

// File: tb/tb_add_nbit_serial.sv
module tb_add_nbit_serial;

   typedef struct packed {
      logic [31:0] res;
      logic        cry;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        i_vld;
   logic        i_rdy;
   logic [31:0] i_num_a;
   logic [31:0] i_num_b;
   logic        i_cry;
   logic        i_sub;
   int          sel;

   // per-instance signals; sel picks which instance the bench drives/observes
   logic [3:0]  vld_v;
   logic [3:0]  rdy_o_v;
   logic [3:0]  vld_o_v;
   logic [3:0]  cry_o_v;
   logic [3:0]  ovf_o_v;
   logic [0:0]  res0;
   logic [31:0] res1, res2, res3;

   logic        o_rdy;
   logic        o_vld;
   logic [31:0] o_res;
   logic        o_cry;
   logic        o_ovf;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb[$];
   logic ii_en   = 1'b0;

   always_comb begin
      for (int k = 0; k < 4; k++) vld_v[k] = i_vld && (sel == k);
   end

   always_comb begin
      o_rdy = rdy_o_v[sel[1:0]];
      o_vld = vld_o_v[sel[1:0]];
      o_cry = cry_o_v[sel[1:0]];
      o_ovf = ovf_o_v[sel[1:0]];
      case (sel)
         0:       o_res = {31'd0, res0};
         1:       o_res = res1;
         2:       o_res = res2;
         default: o_res = res3;
      endcase
   end

   add_nbit_serial #(.DATA_W(1), .DIGIT_W(1)) u_w1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld_v[0]), .o_rdy(rdy_o_v[0]),
      .i_num_a(i_num_a[0:0]), .i_num_b(i_num_b[0:0]), .i_cry(i_cry), .i_sub(i_sub),
      .o_vld(vld_o_v[0]), .i_rdy(i_rdy), .o_res(res0), .o_cry(cry_o_v[0]), .o_ovf(ovf_o_v[0]));

   add_nbit_serial #(.DATA_W(32), .DIGIT_W(4)) u_d4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld_v[1]), .o_rdy(rdy_o_v[1]),
      .i_num_a(i_num_a), .i_num_b(i_num_b), .i_cry(i_cry), .i_sub(i_sub),
      .o_vld(vld_o_v[1]), .i_rdy(i_rdy), .o_res(res1), .o_cry(cry_o_v[1]), .o_ovf(ovf_o_v[1]));

   add_nbit_serial #(.DATA_W(32), .DIGIT_W(1)) u_d1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld_v[2]), .o_rdy(rdy_o_v[2]),
      .i_num_a(i_num_a), .i_num_b(i_num_b), .i_cry(i_cry), .i_sub(i_sub),
      .o_vld(vld_o_v[2]), .i_rdy(i_rdy), .o_res(res2), .o_cry(cry_o_v[2]), .o_ovf(ovf_o_v[2]));

   add_nbit_serial #(.DATA_W(32), .DIGIT_W(32)) u_d32 (
      .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld_v[3]), .o_rdy(rdy_o_v[3]),
      .i_num_a(i_num_a), .i_num_b(i_num_b), .i_cry(i_cry), .i_sub(i_sub),
      .o_vld(vld_o_v[3]), .i_rdy(i_rdy), .o_res(res3), .o_cry(cry_o_v[3]), .o_ovf(ovf_o_v[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   function automatic int width_of(input int s);
      return (s == 0) ? 1 : 32;
   endfunction

   function automatic int n_of(input int s);
      case (s)
         1:       return 8;
         2:       return 32;
         default: return 1;
      endcase
   endfunction

   // Reference: straight wide addition of A and the (optionally inverted) B.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic cry, input logic sub, input int w);
      exp_t        e;
      logic [32:0] mask;
      logic [32:0] aa, bb, s;
      mask  = (w == 32) ? 33'h0_FFFF_FFFF : 33'h1;
      aa    = {1'b0, a} & mask;
      bb    = {1'b0, b ^ {32{sub}}} & mask;
      s     = aa + bb + {32'd0, cry ^ sub};
      e.res = s[31:0] & mask[31:0];
      e.cry = s[w];
      e.ovf = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
      return e;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Monitor: pushes expectations on acceptance, compares on result handshake.
   initial begin : monitor
      int   acc_cyc  = 0;
      int   prev_acc = 0;
      bit   have_prev = 0;
      logic prev_vld = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
            prev_vld  = 0;
            have_prev = 0;
         end else begin
            if (!ii_en) have_prev = 0;
            if (i_vld && o_rdy) begin
               sb.push_back(model(i_num_a, i_num_b, i_cry, i_sub, width_of(sel)));
               acc_cyc = cyc + 1;
               if (ii_en && have_prev)
                  check_val("init_interval", 32'(acc_cyc - prev_acc), 32'(n_of(sel) + 2));
               prev_acc  = acc_cyc;
               have_prev = 1;
            end
            if (o_vld && !prev_vld)
               check_val("latency", 32'(cyc - acc_cyc), 32'(n_of(sel)));
            if (o_vld && i_rdy) begin
               if (sb.size() == 0) begin
                  check_val("unexpected_result", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check_val("res", o_res, e.res);
                  check_val("cry", {31'd0, o_cry}, {31'd0, e.cry});
                  check_val("ovf", {31'd0, o_ovf}, {31'd0, e.ovf});
               end
            end
            prev_vld = o_vld;
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic cry, input logic sub);
      bit ok = 0;
      i_num_a = a; i_num_b = b; i_cry = cry; i_sub = sub; i_vld = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (o_rdy) begin ok = 1; break; end
      end
      if (!ok) check_val("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      i_vld = 1'b0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (sb.size() == 0 && o_rdy) begin ok = 1; break; end
      end
      if (!ok) check_val("drain_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic stream(input int count);
      ii_en = 1'b1;
      i_rdy = 1'b1;
      for (int k = 0; k < count; k++) begin
         bit ok = 0;
         i_num_a = $urandom; i_num_b = $urandom;
         i_cry = 1'($urandom_range(0, 1)); i_sub = 1'($urandom_range(0, 1));
         i_vld = 1'b1;
         for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (o_rdy) begin ok = 1; break; end
         end
         if (!ok) check_val("stream_timeout", 32'd0, 32'd1);
         @(posedge clk); #1;
      end
      i_vld = 1'b0;
      ii_en = 1'b0;
      drain();
   endtask

   initial begin
      rst_n = 1'b0; i_vld = 1'b0; i_rdy = 1'b1;
      i_num_a = '0; i_num_b = '0; i_cry = 1'b0; i_sub = 1'b0; sel = 1;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 4; s++) begin
         sel = s; #1;
         check_val("rst_vld", {31'd0, o_vld}, 32'd0);
         check_val("rst_rdy", {31'd0, o_rdy}, 32'd1);
         check_val("rst_res", o_res, 32'd0);
         check_val("rst_cry_ovf", {30'd0, o_cry, o_ovf}, 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1-bit half adder, all four operand combinations
      sel = 0;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] ab;
         ab = 2'(k);
         send({31'd0, ab[1]}, {31'd0, ab[0]}, 1'b0, 1'b0);
         drain();
      end

      // 32/4 add, carry-in, overflow
      sel = 1;
      send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0); drain();
      send(32'd0, 32'd0, 1'b1, 1'b0);         drain();
      send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0); drain();

      // backpressure in DONE with new operands pulsed at the input
      i_rdy = 1'b0;
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      begin
         bit ok = 0;
         for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (o_vld) begin ok = 1; break; end
         end
         if (!ok) check_val("bp_vld_timeout", 32'd0, 32'd1);
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         i_vld = 1'b1; i_num_a = $urandom; i_num_b = $urandom; i_sub = ~i_sub;
         @(negedge clk);
         check_val("bp_vld", {31'd0, o_vld}, 32'd1);
         check_val("bp_res", o_res, 32'h2345_6789);
         check_val("bp_rdy", {31'd0, o_rdy}, 32'd0);
      end
      @(posedge clk); #1;
      i_vld = 1'b0; i_sub = 1'b0; i_rdy = 1'b1;
      @(posedge clk); #1;
      check_val("bp_release_rdy", {31'd0, o_rdy}, 32'd1);
      check_val("bp_sb_empty", 32'(sb.size()), 32'd0);
      stream(3);

      // 32/4 subtract
      send(32'd5, 32'd7, 1'b0, 1'b1);         drain();
      send(32'd7, 32'd5, 1'b1, 1'b1);         drain();
      send(32'h8000_0000, 32'd1, 1'b0, 1'b1); drain();

      // asynchronous reset three cycles into CALC
      send(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_val("arst_vld", {31'd0, o_vld}, 32'd0);
      check_val("arst_rdy", {31'd0, o_rdy}, 32'd1);
      check_val("arst_res", o_res, 32'd0);
      check_val("arst_cry_ovf", {30'd0, o_cry, o_ovf}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      sel = 2; stream(1000);
      sel = 3; stream(1000);

      check_val("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
